// File: rtl/led_port_viewer_if.sv
// rtl/led_port_viewer_if.sv - port data, button and LED/select bundle for led_port_viewer
interface led_port_viewer_if #(
    parameter int WIDTH  = 32,
    parameter int NPORTS = 4,
    parameter int LED_W  = 16
);
    localparam int NSLICE  = WIDTH / LED_W;
    localparam int SEL_W   = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int SLICE_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    logic [NPORTS*WIDTH-1:0] port_data;
    logic                    btn_next;
    logic                    btn_slice;
    logic [LED_W-1:0]        led;
    logic [SEL_W-1:0]        sel;
    logic [SLICE_W-1:0]      slice;

    modport master (
        output port_data, btn_next, btn_slice,
        input  led, sel, slice
    );

    modport slave (
        input  port_data, btn_next, btn_slice,
        output led, sel, slice
    );
endinterface

// File: rtl/led_port_viewer.sv
// rtl/led_port_viewer.sv - debounced-button viewer of processor ports on LEDs; LED_VIEW_FLASH_EN adds a channel indicator
module led_port_viewer #(
    parameter int WIDTH           = 32,
    parameter int NPORTS          = 4,
    parameter int LED_W           = 16,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int FLASH_CYCLES    = 50000000
) (
    input  logic             clk,
    input  logic             reset,
    led_port_viewer_if.slave bus
);
    localparam int NSLICE  = WIDTH / LED_W;
    localparam int SEL_W   = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int SLICE_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SEL_W-1:0]   SEL_LAST   = SEL_W'(NPORTS - 1);
    localparam logic [SLICE_W-1:0] SLICE_LAST = SLICE_W'(NSLICE - 1);

    // bit 0 = next button, bit 1 = slice button
    logic [1:0]       w_btn;
    logic [1:0]       r_sync1;
    logic [1:0]       r_s;
    logic [1:0]       r_d;
    logic [1:0]       r_d_q;
    logic [CNT_W-1:0] r_cnt [2];
    logic [1:0]       w_press;
    logic             w_next;
    logic             w_slc;

    logic [SEL_W-1:0]   r_sel;
    logic [SLICE_W-1:0] r_slice;
    logic [LED_W-1:0]   r_led;
    logic [LED_W-1:0]   w_led_data;
    logic [LED_W-1:0]   w_led_next;
    logic [WIDTH-1:0]   w_ports [NPORTS];
    logic [WIDTH-1:0]   w_port_sel;

    assign w_btn   = {bus.btn_slice, bus.btn_next};
    assign w_press = r_d & ~r_d_q;
    assign w_next  = w_press[0];
    assign w_slc   = w_press[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_s     <= '0;
            r_d     <= '0;
            r_d_q   <= '0;
            for (int b = 0; b < 2; b++) r_cnt[b] <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_s     <= r_sync1;
            r_d_q   <= r_d;
            // any agreement between s and d restarts the count, rejecting glitches
            for (int b = 0; b < 2; b++) begin
                if (r_s[b] == r_d[b]) begin
                    r_cnt[b] <= '0;
                end else if (r_cnt[b] == CNT_LAST) begin
                    r_d[b]   <= r_s[b];
                    r_cnt[b] <= '0;
                end else begin
                    r_cnt[b] <= r_cnt[b] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel   <= '0;
            r_slice <= '0;
        end else if (w_next) begin
            r_sel   <= (r_sel == SEL_LAST) ? '0 : r_sel + 1'b1;
            r_slice <= '0;
        end else if (w_slc && (NSLICE > 1)) begin
            r_slice <= (r_slice == SLICE_LAST) ? '0 : r_slice + 1'b1;
        end
    end

    for (genvar k = 0; k < NPORTS; k++) begin : g_port
        assign w_ports[k] = bus.port_data[k*WIDTH +: WIDTH];
    end

    assign w_port_sel = w_ports[r_sel];

    if (NSLICE > 1) begin : g_multi_slice
        logic [LED_W-1:0] w_slices [NSLICE];
        for (genvar j = 0; j < NSLICE; j++) begin : g_slice
            assign w_slices[j] = w_port_sel[j*LED_W +: LED_W];
        end
        assign w_led_data = w_slices[r_slice];
    end else begin : g_single_slice
        assign w_led_data = w_port_sel[LED_W-1:0];
    end

`ifdef LED_VIEW_FLASH_EN
    localparam int FL_W = $clog2(FLASH_CYCLES + 1);
    logic [FL_W-1:0] r_flash_cnt;

    // loaded on the same edge sel advances, so the one-hot shows the new sel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flash_cnt <= '0;
        end else if (w_next) begin
            r_flash_cnt <= FL_W'(FLASH_CYCLES);
        end else if (r_flash_cnt != '0) begin
            r_flash_cnt <= r_flash_cnt - 1'b1;
        end
    end

    always_comb begin
        w_led_next = w_led_data;
        if (r_flash_cnt != '0) w_led_next = LED_W'(1) << r_sel;
    end
`else
    assign w_led_next = w_led_data;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_led <= '0;
        else       r_led <= w_led_next;
    end

    assign bus.led   = r_led;
    assign bus.sel   = r_sel;
    assign bus.slice = r_slice;
endmodule

// File: tb/tb_led_port_viewer.sv
// tb/tb_led_port_viewer.sv - directed scoreboard bench for led_port_viewer
module tb_led_port_viewer;
    logic clk;
    logic reset;

    led_port_viewer_if #(.WIDTH(32), .NPORTS(4), .LED_W(16)) bus ();

    led_port_viewer #(
        .WIDTH(32), .NPORTS(4), .LED_W(16),
        .DEBOUNCE_CYCLES(4), .FLASH_CYCLES(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [18:0] exp;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic [15:0] led,
                              input logic [1:0] sel, input logic slice);
        sb_t e;
        e.tag = tag;
        e.exp = {led, sel, slice};
        sb.push_back(e);
    endtask

    task automatic check_out();
        sb_t         e;
        logic [18:0] obs;
        obs = {bus.led, bus.sel, bus.slice};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty observed=%h expected=<entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp)
            else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic press(input bit nxt, input bit slc);
        bus.btn_next  = nxt;
        bus.btn_slice = slc;
        step(8);
        bus.btn_next  = 1'b0;
        bus.btn_slice = 1'b0;
        step(10);
    endtask

    initial begin
        reset         = 1'b0;
        bus.btn_next  = 1'b0;
        bus.btn_slice = 1'b0;
        bus.port_data = {32'h5555_6666, 32'h3333_4444, 32'h1111_2222, 32'hDEAD_BEEF};
        #1 reset = 1'b1;
        expect_out("reset_async", 16'h0000, 2'd0, 1'b0);
        #1 check_out();
        step(3);
        expect_out("reset_held", 16'h0000, 2'd0, 1'b0);
        check_out();
        reset = 1'b0;
        expect_out("first_edge", 16'hBEEF, 2'd0, 1'b0);
        step(1);
        check_out();

        // held next button: latency and single increment
        bus.btn_next = 1'b1;
        expect_out("lat_edge6", 16'hBEEF, 2'd0, 1'b0);
        step(6);
        check_out();
        expect_out("lat_edge7_sel", 16'hBEEF, 2'd1, 1'b0);
        step(1);
        check_out();
        expect_out("lat_edge8_led", 16'h2222, 2'd1, 1'b0);
        step(1);
        check_out();
        step(2);
        bus.btn_next = 1'b0;
        expect_out("hold_single", 16'h2222, 2'd1, 1'b0);
        step(12);
        check_out();

        // glitch 3 high / 1 low / 3 high must be rejected
        bus.btn_next = 1'b1; step(3);
        bus.btn_next = 1'b0; step(1);
        bus.btn_next = 1'b1; step(3);
        bus.btn_next = 1'b0;
        expect_out("glitch_reject", 16'h2222, 2'd1, 1'b0);
        step(12);
        check_out();

        expect_out("next_to_2", 16'h4444, 2'd2, 1'b0); press(1, 0); check_out();
        expect_out("next_to_3", 16'h6666, 2'd3, 1'b0); press(1, 0); check_out();
        expect_out("wrap_to_0", 16'hBEEF, 2'd0, 1'b0); press(1, 0); check_out();
        expect_out("wrap_to_1", 16'h2222, 2'd1, 1'b0); press(1, 0); check_out();
        expect_out("wrap_to_2", 16'h4444, 2'd2, 1'b0); press(1, 0); check_out();
        expect_out("wrap_to_3", 16'h6666, 2'd3, 1'b0); press(1, 0); check_out();
        expect_out("back_to_0", 16'hBEEF, 2'd0, 1'b0); press(1, 0); check_out();

        expect_out("slice_hi", 16'hDEAD, 2'd0, 1'b1); press(0, 1); check_out();
        expect_out("slice_wrap", 16'hBEEF, 2'd0, 1'b0); press(0, 1); check_out();
        expect_out("slice_hi_again", 16'hDEAD, 2'd0, 1'b1); press(0, 1); check_out();
        expect_out("both_next_wins", 16'h2222, 2'd1, 1'b0); press(1, 1); check_out();

        bus.port_data[63:32] = 32'h0000_ABCD;
        expect_out("live_track", 16'hABCD, 2'd1, 1'b0);
        step(1);
        check_out();

        // reset during debounce discards the pending press
        bus.btn_next = 1'b1;
        step(4);
        #2 reset = 1'b1;
        expect_out("reset_mid_debounce", 16'h0000, 2'd0, 1'b0);
        #1 check_out();
        bus.btn_next = 1'b0;
        step(2);
        reset = 1'b0;
        expect_out("no_pulse_after_reset", 16'hBEEF, 2'd0, 1'b0);
        step(12);
        check_out();

        expect_out("to_port1", 16'hABCD, 2'd1, 1'b0); press(1, 0); check_out();

        // channel indicator on the press to sel=2
        bus.btn_next = 1'b1;
`ifdef LED_VIEW_FLASH_EN
        expect_out("flash_start", 16'h0004, 2'd2, 1'b0);
`else
        expect_out("direct_edge8", 16'h4444, 2'd2, 1'b0);
`endif
        step(8);
        check_out();
`ifdef LED_VIEW_FLASH_EN
        expect_out("flash_last", 16'h0004, 2'd2, 1'b0);
`else
        expect_out("direct_edge15", 16'h4444, 2'd2, 1'b0);
`endif
        step(7);
        check_out();
        bus.btn_next = 1'b0;
        expect_out("after_flash", 16'h4444, 2'd2, 1'b0);
        step(1);
        check_out();

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
